song_reader: RTL and testbench
==============================

Name: song_reader

Overview:
- Sequencer between the top-level music-player MCU and the note player.
- When `play` is high, walks the selected song's notes in the song ROM and issues each note to the note player with a one-cycle `new_note` strobe.
- Waits for `note_done` before fetching the next note.
- Pulses `song_done` back to the MCU at end of song.

Parameters:
- NOTE_W, 6, note code width.
- DUR_W, 6, duration width (units of the note player's beat tick).
- IDX_W, 5, note-index width; 2**IDX_W notes per song.
- SONG_W, 2, song-select width.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-low reset; asserted when 0, sampled on rising edge of clk.
- play  input  1  MCU play level; 1 = run, 0 = pause.
- song  input  SONG_W  song select from MCU.
- rom_addr  output  SONG_W+IDX_W  song ROM address {song_r, idx}.
- rom_data  input  NOTE_W+DUR_W  ROM word {note, duration}; synchronous ROM, 1-cycle read latency.
- note  output  NOTE_W  registered note to note player.
- duration  output  DUR_W  registered duration to note player.
- new_note  output  1  one-cycle strobe; note/duration valid.
- note_done  input  1  note player finished current note.
- song_done  output  1  one-cycle end-of-song pulse to MCU.

Behaviour:
- Reset (reset==0 at edge):
  - state=IDLE, idx=0, song_r=0.
  - note=0, duration=0, new_note=0, song_done=0, rom_addr=0.
  - Reset mid-operation aborts immediately and issues no pulses.
- rom_addr = {song_r, idx}, driven from registers.
- States:
  - IDLE: if play, latch song_r<=song and go to FETCH; else stay.
  - FETCH: address presented to ROM. If play, go to ISSUE; else hold.
  - ISSUE: rom_data valid.
    - If duration field==0 (end marker), go to DONE and do not issue.
    - Else if play: note<=rom_data[NOTE_W+DUR_W-1:DUR_W], duration<=rom_data[DUR_W-1:0], new_note=1 for exactly this one cycle, go to WAIT_NOTE.
    - Else hold; new_note stays 0 and the ROM is re-read.
  - WAIT_NOTE: on note_done:
    - if idx==all-ones, go to DONE;
    - else idx<=idx+1 and go to FETCH.
    - note_done is accepted regardless of play.
  - DONE: song_done=1 for one cycle, idx<=0, go to IDLE.
- Latency: play sampled high in IDLE at edge N gives new_note high in the cycle after edge N+2. After note_done, the next new_note follows two cycles later.
- note/duration hold their last value until the next issue.
- note_done outside WAIT_NOTE is ignored.
- A note_done arriving in the same cycle as new_note is ignored.
- Song change: if song != song_r in any state except IDLE/DONE:
  - abort to IDLE with idx=0 and no song_done;
  - the next play press starts the new song at note 0.
  - Song change takes priority over note_done.
- Index wrap: after note 2**IDX_W-1 completes, the song ends (DONE); idx never wraps silently.
- song_done and new_note are never high in the same cycle.

Optional Feature:
- Macro SONG_READER_REPEAT_EN.
- Defined:
  - DONE still pulses song_done and clears idx.
  - If play is high in the DONE cycle, goes straight to FETCH (loops the song, song_r unchanged).
  - Otherwise goes to IDLE.
- Undefined: DONE always returns to IDLE.

Test Plan:
- Reset: hold reset=0 three cycles with play=1 -> new_note=0, song_done=0, rom_addr=0. Release -> first new_note with rom_addr=0 two cycles after the first edge that samples play=1.
- Basic walk: song=2, ROM[64..66]={5,4},{7,3},{9,0}, note_done one cycle after each new_note -> two new_note strobes with note=5,dur=4 then 7,3; then song_done pulses once; state IDLE; idx=0.
- Pause: drop play during FETCH of note 1 for 5 cycles -> no new_note during the pause. Restore play -> new_note with the same note 1 two cycles later.
- Full-length song: all 32 entries nonzero duration for song=0 -> 32 new_note strobes, rom_addr 0..31; song_done after the 32nd note_done; no address 32 ever driven.
- Song change: switch song 1->3 during WAIT_NOTE with note_done high in the same cycle -> abort to IDLE, no song_done, idx=0. Next play -> rom_addr=96.
- Repeat: compile with SONG_READER_REPEAT_EN, play held high, 2-note song -> song_done pulse followed two cycles later by new_note of note 0. Without the macro -> no further new_note.

Source files
------------

// File: rtl/song_reader.sv
// Song sequencer: walks the selected song in the song ROM and hands each note
// to the note player. Optional SONG_READER_REPEAT_EN loops the song while play stays high.
module song_reader #(
  parameter int NOTE_W = 6,
  parameter int DUR_W  = 6,
  parameter int IDX_W  = 5,
  parameter int SONG_W = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      play,
  input  logic [SONG_W-1:0]         song,
  output logic [SONG_W+IDX_W-1:0]   rom_addr,
  input  logic [NOTE_W+DUR_W-1:0]   rom_data,
  output logic [NOTE_W-1:0]         note,
  output logic [DUR_W-1:0]          duration,
  output logic                      new_note,
  input  logic                      note_done,
  output logic                      song_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_ISSUE,
    S_WAIT_NOTE,
    S_DONE
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [IDX_W-1:0]    r_idx;
  logic [SONG_W-1:0]   r_song;
  logic [NOTE_W-1:0]   r_note;
  logic [DUR_W-1:0]    r_dur;
  logic                r_new_note;
  logic                r_song_done;

  logic                w_latch;
  logic                w_issue;
  logic                w_idx_inc;
  logic                w_idx_clr;
  logic                w_song_chg;
  logic [DUR_W-1:0]    w_rom_dur;

  assign w_song_chg = (song != r_song);
  assign w_rom_dur  = rom_data[DUR_W-1:0];

  always_comb begin
    w_state_nxt = r_state;
    w_latch     = 1'b0;
    w_issue     = 1'b0;
    w_idx_inc   = 1'b0;
    w_idx_clr   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (play) begin
          w_latch     = 1'b1;
          w_state_nxt = S_FETCH;
        end
      end
      S_FETCH: begin
        if (w_song_chg) begin
          w_idx_clr   = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (play) begin
          w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (w_song_chg) begin
          w_idx_clr   = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (w_rom_dur == '0) begin
          w_state_nxt = S_DONE;
        end else if (play) begin
          w_issue     = 1'b1;
          w_state_nxt = S_WAIT_NOTE;
        end
      end
      S_WAIT_NOTE: begin
        // note_done coinciding with the new_note strobe belongs to the previous note
        if (w_song_chg) begin
          w_idx_clr   = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (note_done && !r_new_note) begin
          if (&r_idx) begin
            w_state_nxt = S_DONE;
          end else begin
            w_idx_inc   = 1'b1;
            w_state_nxt = S_FETCH;
          end
        end
      end
      S_DONE: begin
        w_idx_clr = 1'b1;
`ifdef SONG_READER_REPEAT_EN
        w_state_nxt = play ? S_FETCH : S_IDLE;
`else
        w_state_nxt = S_IDLE;
`endif
      end
      default: begin
        w_idx_clr   = 1'b1;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_song      <= '0;
      r_note      <= '0;
      r_dur       <= '0;
      r_new_note  <= 1'b0;
      r_song_done <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_new_note  <= w_issue;
      r_song_done <= (r_state == S_DONE);
      if (w_latch) begin
        r_song <= song;
      end
      if (w_idx_clr) begin
        r_idx <= '0;
      end else if (w_idx_inc) begin
        r_idx <= r_idx + 1'b1;
      end
      if (w_issue) begin
        r_note <= rom_data[NOTE_W+DUR_W-1:DUR_W];
        r_dur  <= w_rom_dur;
      end
    end
  end

  assign rom_addr  = {r_song, r_idx};
  assign note      = r_note;
  assign duration  = r_dur;
  assign new_note  = r_new_note;
  assign song_done = r_song_done;

endmodule

// File: tb/tb_song_reader.sv
// Scoreboard bench for song_reader: a song-level model queues expected notes and
// end-of-song events, a monitor pops and compares whenever the DUT strobes.
module tb_song_reader;
  localparam int NOTE_W = 6;
  localparam int DUR_W  = 6;
  localparam int IDX_W  = 5;
  localparam int SONG_W = 2;
  localparam int AW     = SONG_W + IDX_W;
  localparam int NSONG  = 2 ** IDX_W;
`ifdef SONG_READER_REPEAT_EN
  localparam bit REPEAT = 1'b1;
`else
  localparam bit REPEAT = 1'b0;
`endif

  logic                    clk = 1'b0;
  logic                    reset;
  logic                    play;
  logic [SONG_W-1:0]       song;
  logic [AW-1:0]           rom_addr;
  logic [NOTE_W+DUR_W-1:0] rom_data;
  logic [NOTE_W+DUR_W-1:0] rom [0:(2**AW)-1];
  logic [NOTE_W-1:0]       note;
  logic [DUR_W-1:0]        duration;
  logic                    new_note;
  logic                    note_done;
  logic                    song_done;
  logic                    nd_resp;
  logic                    nd_man;

  typedef struct {
    bit is_done;
    int note;
    int dur;
    int addr;
  } exp_t;

  exp_t exp_q[$];
  exp_t run_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   resp_en = 1'b0;
  bit   pending = 1'b0;
  bit   prev_play = 1'b0;

  assign note_done = nd_resp | nd_man;

  always #5 clk = ~clk;

  always @(posedge clk) rom_data <= rom[rom_addr];

  song_reader #(
    .NOTE_W(NOTE_W),
    .DUR_W (DUR_W),
    .IDX_W (IDX_W),
    .SONG_W(SONG_W)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .play     (play),
    .song     (song),
    .rom_addr (rom_addr),
    .rom_data (rom_data),
    .note     (note),
    .duration (duration),
    .new_note (new_note),
    .note_done(note_done),
    .song_done(song_done)
  );

  task automatic check(input bit ok, input string name, input int act, input int req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Fill one song: random notes, nonzero durations, end marker at index len (none if len>=32).
  function automatic void fill_song(input int s, input int len);
    logic [NOTE_W-1:0] n;
    logic [DUR_W-1:0]  d;
    for (int i = 0; i < NSONG; i++) begin
      n = NOTE_W'($urandom);
      d = DUR_W'($urandom_range(1, (2 ** DUR_W) - 1));
      if (i == len) d = '0;
      rom[s * NSONG + i] = {n, d};
    end
  endfunction

  // Reference model: the song is its notes in order up to the first zero duration
  // (or the end of the song's slot), followed by one end-of-song event.
  function automatic void expect_song(input int s);
    logic [NOTE_W+DUR_W-1:0] w;
    exp_t e;
    run_q.delete();
    for (int i = 0; i < NSONG; i++) begin
      w = rom[s * NSONG + i];
      if (w[DUR_W-1:0] == '0) break;
      e.is_done = 1'b0;
      e.note    = int'(w[NOTE_W+DUR_W-1:DUR_W]);
      e.dur     = int'(w[DUR_W-1:0]);
      e.addr    = s * NSONG + i;
      run_q.push_back(e);
    end
    e.is_done = 1'b1;
    e.note = 0;
    e.dur  = 0;
    e.addr = 0;
    run_q.push_back(e);
    foreach (run_q[k]) exp_q.push_back(run_q[k]);
  endfunction

  // Monitor / scoreboard
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset === 1'b1) begin
        if (new_note) begin
          check(!song_done, "strobe_overlap", int'(song_done), 0);
          check(!pending, "issue_before_ack", int'(pending), 0);
          check(prev_play, "issue_while_paused", int'(prev_play), 1);
          check(exp_q.size() > 0, "unexpected_note", exp_q.size(), 1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check(!e.is_done, "note_instead_of_done", 1, 0);
            check(note == NOTE_W'(e.note), "note", int'(note), e.note);
            check(duration == DUR_W'(e.dur), "duration", int'(duration), e.dur);
            check(rom_addr == AW'(e.addr), "rom_addr", int'(rom_addr), e.addr);
          end
          pending = 1'b1;
        end else if (song_done) begin
          check(!pending, "done_before_ack", int'(pending), 0);
          check(exp_q.size() > 0, "unexpected_song_done", exp_q.size(), 1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check(e.is_done, "done_instead_of_note", 0, 1);
          end
          check(rom_addr[IDX_W-1:0] == '0, "idx_cleared", int'(rom_addr[IDX_W-1:0]), 0);
        end
        if (note_done && !new_note) pending = 1'b0;
      end else begin
        pending = 1'b0;
      end
      prev_play = play;
    end
  end

  // Note player stand-in: may raise a stray note_done in the strobe cycle, then
  // acknowledges 1..3 cycles later.
  initial begin
    nd_resp = 1'b0;
    forever begin
      tick();
      nd_resp = 1'b0;
      if (resp_en && new_note) begin
        nd_resp = ($urandom_range(0, 1) == 1);
        repeat ($urandom_range(1, 3)) begin
          tick();
          nd_resp = 1'b0;
        end
        nd_resp = 1'b1;
      end
    end
  end

  // Runs the current song to completion; handles looping when repeat is built in.
  task automatic finish_run(input bit rand_play);
    int reps = 0;
    bit done = 1'b0;
    for (int cyc = 0; cyc < 5000 && !done; cyc++) begin
      if (song_done) begin
        if (REPEAT && play) begin
          if (reps >= 2) begin
            // stop the loop by parking in FETCH and switching song
            play = 1'b0;
            tick();
            song = song + 1'b1;
            tick();
            tick();
            check(rom_addr[IDX_W-1:0] == '0, "abort_idx", int'(rom_addr[IDX_W-1:0]), 0);
            song = song - 1'b1;
            done = 1'b1;
          end else begin
            reps++;
            foreach (run_q[k]) exp_q.push_back(run_q[k]);
            play = 1'b1;
            tick();
            check(!new_note, "repeat_early", int'(new_note), 0);
            tick();
            check(new_note == 1'b1, "repeat_latency", int'(new_note), 1);
          end
        end else begin
          play = 1'b0;
          for (int q = 0; q < 4; q++) begin
            tick();
            check(!new_note, "no_restart", int'(new_note), 0);
          end
          done = 1'b1;
        end
      end else begin
        if (rand_play) play = ($urandom_range(0, 3) != 0);
        tick();
      end
    end
    check(done, "run_complete", int'(done), 1);
    check(exp_q.size() == 0, "queue_drained", exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    int lat;
    reset  = 1'b0;
    play   = 1'b1;
    song   = '0;
    nd_man = 1'b0;
    for (int s = 0; s < 4; s++) fill_song(s, NSONG);

    // Reset held with play high: nothing may come out.
    repeat (3) begin
      tick();
      check(!new_note, "reset_new_note", int'(new_note), 0);
      check(!song_done, "reset_song_done", int'(song_done), 0);
      check(rom_addr == '0, "reset_rom_addr", int'(rom_addr), 0);
    end

    // Full-length song 0, first-note latency from reset release.
    expect_song(0);
    resp_en = 1'b1;
    reset   = 1'b1;
    lat     = 0;
    while (!new_note && lat < 10) begin
      tick();
      lat++;
    end
    check(lat == 3, "first_note_latency", lat, 3);
    finish_run(1'b0);

    // Basic walk, song 2, with pauses.
    rom[64] = {6'd5, 6'd4};
    rom[65] = {6'd7, 6'd3};
    rom[66] = {6'd9, 6'd0};
    song = 2'd2;
    tick();
    expect_song(2);
    finish_run(1'b1);

    // Song change during WAIT_NOTE with note_done in the same cycle.
    fill_song(1, 4);
    fill_song(3, $urandom_range(1, NSONG));
    resp_en = 1'b0;
    song = 2'd1;
    tick();
    begin
      exp_t e;
      e.is_done = 1'b0;
      e.note    = int'(rom[32][NOTE_W+DUR_W-1:DUR_W]);
      e.dur     = int'(rom[32][DUR_W-1:0]);
      e.addr    = 32;
      exp_q.push_back(e);
    end
    play = 1'b1;
    lat  = 0;
    while (!new_note && lat < 10) begin
      tick();
      lat++;
    end
    check(new_note == 1'b1, "chg_first_note", int'(new_note), 1);
    tick();
    song   = 2'd3;
    nd_man = 1'b1;
    tick();
    nd_man = 1'b0;
    play   = 1'b0;
    check(rom_addr[IDX_W-1:0] == '0, "chg_abort_idx", int'(rom_addr[IDX_W-1:0]), 0);
    check(rom_addr[AW-1:IDX_W] == 2'd1, "chg_song_r_kept", int'(rom_addr[AW-1:IDX_W]), 1);
    tick();
    tick();
    check(exp_q.size() == 0, "chg_queue", exp_q.size(), 0);
    expect_song(3);
    resp_en = 1'b1;
    finish_run(1'b1);

    // Randomised songs of varied length.
    for (int r = 0; r < 8; r++) begin
      int s;
      int len;
      s   = $urandom_range(0, 3);
      len = ($urandom_range(0, 3) == 0) ? NSONG : $urandom_range(1, NSONG - 1);
      fill_song(s, len);
      song = SONG_W'(s);
      tick();
      expect_song(s);
      finish_run(1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule
